pixel_fetch_pipe: RTL



---
 rtl/pixel_fetch_pipe_if.sv | 44 ++++
 rtl/pixel_fetch_pipe.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_fetch_pipe_if                                                        |
// | Pixel request / RAM read / palette-index bundle for pixel_fetch_pipe.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
interface pixel_fetch_pipe_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int ADDR_W  = 20,
  parameter int COLOR_W = 4
);
  logic               pix_stb;
  logic [X_W-1:0]     DrawX;
  logic [Y_W-1:0]     DrawY;
  logic [ADDR_W-1:0]  mem_address_out;
  logic               mem_rd;
  logic [COLOR_W-1:0] mem_data_in;
  logic [COLOR_W-1:0] color_index;
  logic               color_valid;
  logic               frame_start;
`ifdef PIXEL_FETCH_FLASH_EN
  logic               flash_req;

  modport master (
    output pix_stb, DrawX, DrawY, mem_data_in, flash_req,
    input  mem_address_out, mem_rd, color_index, color_valid, frame_start
  );
  modport slave (
    input  pix_stb, DrawX, DrawY, mem_data_in, flash_req,
    output mem_address_out, mem_rd, color_index, color_valid, frame_start
  );
`else
  modport master (
    output pix_stb, DrawX, DrawY, mem_data_in,
    input  mem_address_out, mem_rd, color_index, color_valid, frame_start
  );
  modport slave (
    input  pix_stb, DrawX, DrawY, mem_data_in,
    output mem_address_out, mem_rd, color_index, color_valid, frame_start
  );
`endif
endinterface
`default_nettype wire

// File: rtl/pixel_fetch_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pixel_fetch_pipe                                                           |
// | Maps DrawX/DrawY to an image-RAM address and returns a latency-aligned     |
// | palette index. Optional flash effect: define PIXEL_FETCH_FLASH_EN.         |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module pixel_fetch_pipe #(
  parameter int X_W      = 10,
  parameter int Y_W      = 10,
  parameter int ADDR_W   = 20,
  parameter int COLOR_W  = 4,
  parameter int IMG_W    = 226,
  parameter int IMG_H    = 248,
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 0,
  parameter int SCALE_SH = 0,
  parameter int MEM_LAT  = 1,
  parameter int BG_INDEX = 0
`ifdef PIXEL_FETCH_FLASH_EN
  ,
  parameter int FLASH_IDX    = 1,
  parameter int FLASH_ALT    = 15,
  parameter int FLASH_FRAMES = 15
`endif
) (
  input wire                CLK,
  input wire                RESET,
  pixel_fetch_pipe_if.slave bus
);

  localparam logic [X_W:0]        C_ORG_X   = (X_W+1)'(ORIGIN_X);
  localparam logic [Y_W:0]        C_ORG_Y   = (Y_W+1)'(ORIGIN_Y);
  localparam logic [X_W:0]        C_IMG_W   = (X_W+1)'(IMG_W);
  localparam logic [Y_W:0]        C_IMG_H   = (Y_W+1)'(IMG_H);
  localparam logic [ADDR_W-1:0]   C_IMG_W_A = ADDR_W'(IMG_W);
  localparam logic [COLOR_W-1:0]  C_BG      = COLOR_W'(BG_INDEX);

  if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << ADDR_W)) begin : g_addr_overflow
    $error("pixel_fetch_pipe: IMG_W*IMG_H exceeds 2**ADDR_W");
  end
  if (SCALE_SH < 0 || SCALE_SH > 3) begin : g_bad_scale
    $error("pixel_fetch_pipe: SCALE_SH must be 0..3");
  end
  if (MEM_LAT < 1 || MEM_LAT > 4) begin : g_bad_lat
    $error("pixel_fetch_pipe: MEM_LAT must be 1..4");
  end

  logic [X_W:0]        w_rx, w_col;
  logic [Y_W:0]        w_ry, w_row;
  logic                w_in_img, w_is_origin;
  logic [ADDR_W-1:0]   w_row_mul, w_row_base_next, w_addr;
  logic [ADDR_W-1:0]   r_addr, r_row_base;
  logic                r_rd;
  logic [Y_W-1:0]      r_last_y;
  logic [MEM_LAT:0]    r_dl_v, r_dl_in, r_dl_org;
  logic [COLOR_W-1:0]  w_base_idx, w_out_idx, r_ci;
  logic                r_cv, r_fs;

  // Offsets are one bit wider than the coordinates so the MSB acts as a sign.
  assign w_rx        = {1'b0, bus.DrawX} - C_ORG_X;
  assign w_ry        = {1'b0, bus.DrawY} - C_ORG_Y;
  assign w_col       = w_rx >> SCALE_SH;
  assign w_row       = w_ry >> SCALE_SH;
  assign w_in_img    = ~w_rx[X_W] & ~w_ry[Y_W] & (w_col < C_IMG_W) & (w_row < C_IMG_H);
  assign w_is_origin = (bus.DrawX == '0) && (bus.DrawY == '0);

  // The multiply result is only taken when the row changes; otherwise the cached base is reused.
  assign w_row_mul       = ADDR_W'(w_row) * C_IMG_W_A;
  assign w_row_base_next = (bus.DrawY != r_last_y) ? w_row_mul : r_row_base;
  assign w_addr          = w_row_base_next + ADDR_W'(w_col);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_addr     <= '0;
      r_rd       <= 1'b0;
      r_row_base <= '0;
      r_last_y   <= '1;
    end else begin
      r_rd <= bus.pix_stb & w_in_img;
      if (bus.pix_stb) begin
        r_row_base <= w_row_base_next;
        r_last_y   <= bus.DrawY;
        if (w_in_img) begin
          r_addr <= w_addr;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dl_v   <= '0;
      r_dl_in  <= '0;
      r_dl_org <= '0;
    end else begin
      r_dl_v   <= {r_dl_v[MEM_LAT-1:0],   bus.pix_stb};
      r_dl_in  <= {r_dl_in[MEM_LAT-1:0],  w_in_img};
      r_dl_org <= {r_dl_org[MEM_LAT-1:0], w_is_origin};
    end
  end

  assign w_base_idx = r_dl_in[MEM_LAT] ? bus.mem_data_in : C_BG;

`ifdef PIXEL_FETCH_FLASH_EN
  localparam int                  CNT_W       = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0]    C_CNT_LAST  = CNT_W'(FLASH_FRAMES - 1);
  localparam logic [COLOR_W-1:0]  C_FLASH_IDX = COLOR_W'(FLASH_IDX);
  localparam logic [COLOR_W-1:0]  C_FLASH_ALT = COLOR_W'(FLASH_ALT);

  if (FLASH_FRAMES < 1) begin : g_bad_frames
    $error("pixel_fetch_pipe: FLASH_FRAMES must be >= 1");
  end

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_phase, w_phase_nxt, w_origin_evt;

  // The origin pixel leaving the delay line is the frame_start being issued this edge,
  // so the whole new frame (including its first pixel) sees the updated phase.
  assign w_origin_evt = r_dl_v[MEM_LAT] & r_dl_org[MEM_LAT];

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    if (!bus.flash_req) begin
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b0;
    end else if (w_origin_evt) begin
      if (r_cnt == C_CNT_LAST) begin
        w_cnt_nxt   = '0;
        w_phase_nxt = ~r_phase;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  assign w_out_idx = (w_phase_nxt && (w_base_idx == C_FLASH_IDX)) ? C_FLASH_ALT : w_base_idx;
`else
  assign w_out_idx = w_base_idx;
`endif

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_ci <= '0;
      r_cv <= 1'b0;
      r_fs <= 1'b0;
    end else begin
      r_cv <= r_dl_v[MEM_LAT];
      r_fs <= r_dl_v[MEM_LAT] & r_dl_org[MEM_LAT];
      if (r_dl_v[MEM_LAT]) begin
        r_ci <= w_out_idx;
      end
    end
  end

  assign bus.mem_address_out = r_addr;
  assign bus.mem_rd          = r_rd;
  assign bus.color_index     = r_ci;
  assign bus.color_valid     = r_cv;
  assign bus.frame_start     = r_fs;

endmodule
`default_nettype wire
